// File: rtl/mem_bus_router_if.sv
// Bus between the memory arbiter, the address router and its four slave regions.
// The master modport is the router's view; the slave modport is the surrounding system.
interface mem_bus_router_if;
    logic [26:0] bus_addr;
    logic [31:0] bus_data;
    logic        bus_we;
    logic        bus_start;
    logic [31:0] bus_q;
    logic        bus_done;
    logic [26:0] s_addr;
    logic [31:0] s_data;
    logic        s_we;
    logic [3:0]  s_start;
    logic [3:0]  s_done;
    logic [31:0] s_q0;
    logic [31:0] s_q1;
    logic [31:0] s_q2;
    logic [31:0] s_q3;
    logic        err_unmapped;
    logic        err_timeout;

    modport master (
        input  bus_addr, bus_data, bus_we, bus_start, s_done, s_q0, s_q1, s_q2, s_q3,
        output bus_q, bus_done, s_addr, s_data, s_we, s_start, err_unmapped, err_timeout
    );

    modport slave (
        output bus_addr, bus_data, bus_we, bus_start, s_done, s_q0, s_q1, s_q2, s_q3,
        input  bus_q, bus_done, s_addr, s_data, s_we, s_start, err_unmapped, err_timeout
    );
endinterface

// File: rtl/mem_bus_router.sv
// Decodes arbiter requests into four slave regions, holds the slave handshake and
// returns data, with unmapped-address and slave-timeout error completion.
module mem_bus_router #(
    parameter logic [26:0] S0_BASE  = 27'h0000000,
    parameter logic [26:0] S0_SIZE  = 27'h0800000,
    parameter logic [26:0] S1_BASE  = 27'h0800000,
    parameter logic [26:0] S1_SIZE  = 27'h0400000,
    parameter logic [26:0] S2_BASE  = 27'h0C00000,
    parameter logic [26:0] S2_SIZE  = 27'h0010000,
    parameter logic [26:0] S3_BASE  = 27'h0C10000,
    parameter logic [26:0] S3_SIZE  = 27'h0000100,
    parameter int          TIMEOUT  = 1023,
    parameter logic [31:0] ERR_DATA = 32'h00000000
) (
    input logic             clk,
    input logic             reset,
    mem_bus_router_if.master bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [26:0] BASE [4] = '{S0_BASE, S1_BASE, S2_BASE, S3_BASE};
    localparam logic [26:0] SIZE [4] = '{S0_SIZE, S1_SIZE, S2_SIZE, S3_SIZE};
    localparam logic [9:0]  TO_LAST  = 10'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [9:0]  cnt, cnt_nx;
    logic [1:0]  sel, sel_nx;
    logic [26:0] s_addr_r, s_addr_nx;
    logic [31:0] s_data_r, s_data_nx;
    logic        s_we_r, s_we_nx;
    logic [3:0]  s_start_r, s_start_nx;
    logic [31:0] bus_q_r, bus_q_nx;
    logic        bus_done_r, bus_done_nx;
    logic        err_u_r, err_u_nx;
    logic        err_t_r, err_t_nx;

    logic        hit;
    logic [1:0]  hit_idx;
    logic [26:0] hit_off;
    logic [31:0] sel_q;

    // Scan from the top down so the lowest-numbered matching region is the one kept.
    // The subtract-then-compare form avoids overflow of BASE + SIZE at the top of the map.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        hit_off = 27'd0;
        for (int i = 3; i >= 0; i--) begin
            if ((bus.bus_addr >= BASE[i]) && ((bus.bus_addr - BASE[i]) < SIZE[i])) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
                hit_off = bus.bus_addr - BASE[i];
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    sel_q = bus.s_q0;
            2'd1:    sel_q = bus.s_q1;
            2'd2:    sel_q = bus.s_q2;
            default: sel_q = bus.s_q3;
        endcase
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        sel_nx      = sel;
        s_addr_nx   = s_addr_r;
        s_data_nx   = s_data_r;
        s_we_nx     = s_we_r;
        s_start_nx  = s_start_r;
        bus_q_nx    = bus_q_r;
        bus_done_nx = 1'b0;
        err_u_nx    = 1'b0;
        err_t_nx    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = 10'd0;
                if (bus.bus_start) begin
                    s_data_nx = bus.bus_data;
                    s_we_nx   = bus.bus_we;
                    if (hit) begin
                        s_addr_nx  = hit_off;
                        s_start_nx = 4'b0001 << hit_idx;
                        sel_nx     = hit_idx;
                        state_nx   = ACCESS;
                    end else begin
                        bus_q_nx    = ERR_DATA;
                        bus_done_nx = 1'b1;
                        err_u_nx    = 1'b1;
                        state_nx    = DONE;
                    end
                end
            end
            // A done from the selected slave takes priority over an expiring counter.
            ACCESS: begin
                cnt_nx = cnt + 10'd1;
                if (bus.s_done[sel]) begin
                    bus_q_nx    = sel_q;
                    bus_done_nx = 1'b1;
                    s_start_nx  = 4'b0000;
                    state_nx    = DONE;
                end else if (cnt == TO_LAST) begin
                    bus_q_nx    = ERR_DATA;
                    bus_done_nx = 1'b1;
                    err_t_nx    = 1'b1;
                    s_start_nx  = 4'b0000;
                    state_nx    = DONE;
                end
            end
            DONE: begin
                cnt_nx   = 10'd0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 10'd0;
            sel        <= 2'd0;
            s_addr_r   <= 27'd0;
            s_data_r   <= 32'd0;
            s_we_r     <= 1'b0;
            s_start_r  <= 4'b0000;
            bus_q_r    <= 32'd0;
            bus_done_r <= 1'b0;
            err_u_r    <= 1'b0;
            err_t_r    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sel        <= sel_nx;
            s_addr_r   <= s_addr_nx;
            s_data_r   <= s_data_nx;
            s_we_r     <= s_we_nx;
            s_start_r  <= s_start_nx;
            bus_q_r    <= bus_q_nx;
            bus_done_r <= bus_done_nx;
            err_u_r    <= err_u_nx;
            err_t_r    <= err_t_nx;
        end
    end

    assign bus.s_addr       = s_addr_r;
    assign bus.s_data       = s_data_r;
    assign bus.s_we         = s_we_r;
    assign bus.s_start      = s_start_r;
    assign bus.bus_q        = bus_q_r;
    assign bus.bus_done     = bus_done_r;
    assign bus.err_unmapped = err_u_r;
    assign bus.err_timeout  = err_t_r;

endmodule

// File: tb/tb_mem_bus_router.sv
// Scoreboard bench for mem_bus_router: directed requests push expected slave-side and
// arbiter-side responses; independent negedge monitors pop and compare.
module tb_mem_bus_router;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mem_bus_router_if bus();

    mem_bus_router #(.TIMEOUT(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  start;
        logic [26:0] addr;
        logic [31:0] data;
        logic        we;
    } req_t;

    typedef struct packed {
        logic [31:0] q;
        logic        eu;
        logic        et;
        logic [31:0] cyc;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    req_t cur_req;
    logic req_active = 1'b0;
    logic mon_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  lat [4];
    logic [7:0]  scnt [4];
    logic [31:0] qval [4];
    logic [3:0]  force_done;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave models: each answers once its start has been held for lat[i] cycles.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            scnt[i] <= bus.s_start[i] ? scnt[i] + 8'd1 : 8'd0;
    end

    always_comb begin
        bus.s_done = 4'b0000;
        for (int i = 0; i < 4; i++)
            bus.s_done[i] = force_done[i] | (bus.s_start[i] & (scnt[i] == lat[i]));
        bus.s_q0 = qval[0];
        bus.s_q1 = qval[1];
        bus.s_q2 = qval[2];
        bus.s_q3 = qval[3];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave-side monitor: the held request must match the pushed expectation every cycle.
    always @(negedge clk) begin
        if (bus.s_start != 4'b0000) begin
            if (!req_active) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_start: got %b expected 0000", bus.s_start);
                end else begin
                    cur_req = req_q.pop_front();
                    req_active = 1'b1;
                end
            end
            if (req_active) begin
                checkOutput("s_start", {28'd0, bus.s_start}, {28'd0, cur_req.start});
                checkOutput("s_addr", {5'd0, bus.s_addr}, {5'd0, cur_req.addr});
                checkOutput("s_data", bus.s_data, cur_req.data);
                checkOutput("s_we", {31'd0, bus.s_we}, {31'd0, cur_req.we});
            end
        end else begin
            req_active = 1'b0;
        end
    end

    // Arbiter-side monitor: completion data, error flags and completion cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("err_without_done",
                        {30'd0, bus.err_unmapped & ~bus.bus_done, bus.err_timeout & ~bus.bus_done}, 32'd0);
            if (bus.bus_done === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got bus_done=1 expected 0");
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    checkOutput("bus_q", bus.bus_q, r.q);
                    checkOutput("err_unmapped", {31'd0, bus.err_unmapped}, {31'd0, r.eu});
                    checkOutput("err_timeout", {31'd0, bus.err_timeout}, {31'd0, r.et});
                    checkOutput("done_cycle", cyc, r.cyc);
                end
            end
        end
    end

    // Issues one request, holds start until done, and drops it like the arbiter does.
    task automatic applyStimulus(input logic [26:0] addr, input logic [31:0] data, input logic we,
                                 input logic [3:0] exp_start, input logic [26:0] exp_saddr,
                                 input logic [31:0] exp_q, input logic exp_eu, input logic exp_et,
                                 input int exp_lat);
        logic done_seen;
        @(negedge clk);
        bus.bus_addr  = addr;
        bus.bus_data  = data;
        bus.bus_we    = we;
        bus.bus_start = 1'b1;
        if (exp_start != 4'b0000)
            req_q.push_back('{exp_start, exp_saddr, data, we});
        rsp_q.push_back('{exp_q, exp_eu, exp_et, 32'(cyc + exp_lat)});
        done_seen = 1'b0;
        for (int n = 0; n < 40 && !done_seen; n++) begin
            @(negedge clk);
            if (bus.bus_done === 1'b1) done_seen = 1'b1;
        end
        bus.bus_start = 1'b0;
        if (!done_seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_wait: got no bus_done within 40 cycles expected completion for addr %h", addr);
            rsp_q.delete();
            req_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation time limit expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.bus_addr  = 27'd0;
        bus.bus_data  = 32'd0;
        bus.bus_we    = 1'b0;
        bus.bus_start = 1'b0;
        force_done    = 4'b0000;
        for (int i = 0; i < 4; i++) lat[i] = 8'd0;
        qval[0] = 32'hCAFEBABE;
        qval[1] = 32'h11110001;
        qval[2] = 32'h22220002;
        qval[3] = 32'hDEAD0003;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_bus_done", {31'd0, bus.bus_done}, 32'd0);
        checkOutput("reset_bus_q", bus.bus_q, 32'd0);
        checkOutput("reset_s_start", {28'd0, bus.s_start}, 32'd0);
        checkOutput("reset_s_addr", {5'd0, bus.s_addr}, 32'd0);
        checkOutput("reset_errs", {30'd0, bus.err_unmapped, bus.err_timeout}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // SDRAM read, slave answers in its third cycle
        lat[0] = 8'd2;
        applyStimulus(27'h0000010, 32'h0, 1'b0, 4'b0001, 27'h10, 32'hCAFEBABE, 1'b0, 1'b0, 4);

        // I/O write with base offset
        lat[3] = 8'd1;
        applyStimulus(27'h0C10005, 32'h12345678, 1'b1, 4'b1000, 27'h5, 32'hDEAD0003, 1'b0, 1'b0, 3);

        // Unmapped, top of address space and one word past the I/O region
        applyStimulus(27'h7FFFFFF, 32'h0, 1'b0, 4'b0000, 27'h0, 32'h0, 1'b1, 1'b0, 1);
        applyStimulus(27'h0C10100, 32'hAAAA5555, 1'b1, 4'b0000, 27'h0, 32'h0, 1'b1, 1'b0, 1);

        // Flash never answers: timeout after 8 access cycles, then a late done is ignored
        lat[1] = 8'd100;
        applyStimulus(27'h0800100, 32'h0BADF00D, 1'b0, 4'b0010, 27'h100, 32'h0, 1'b0, 1'b1, 9);
        force_done[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("late_done_bus_done", {31'd0, bus.bus_done}, 32'd0);
            checkOutput("late_done_s_start", {28'd0, bus.s_start}, 32'd0);
        end
        force_done[1] = 1'b0;

        // Wrong-slave done during a region 0 access at its last word
        force_done[2] = 1'b1;
        lat[0] = 8'd3;
        applyStimulus(27'h07FFFFF, 32'h0, 1'b0, 4'b0001, 27'h7FFFFF, 32'hCAFEBABE, 1'b0, 1'b0, 5);
        force_done[2] = 1'b0;

        // First flash word with minimum latency, last VRAM word
        lat[1] = 8'd0;
        applyStimulus(27'h0800000, 32'h0, 1'b0, 4'b0010, 27'h0, 32'h11110001, 1'b0, 1'b0, 2);
        lat[2] = 8'd0;
        applyStimulus(27'h0C0FFFF, 32'h55AA55AA, 1'b1, 4'b0100, 27'hFFFF, 32'h22220002, 1'b0, 1'b0, 2);

        // Reset while an SDRAM access is pending, then a normal read
        lat[0] = 8'd100;
        @(negedge clk);
        bus.bus_addr  = 27'h0000040;
        bus.bus_data  = 32'h0;
        bus.bus_we    = 1'b0;
        bus.bus_start = 1'b1;
        req_q.push_back('{4'b0001, 27'h40, 32'h0, 1'b0});
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.bus_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_s_start", {28'd0, bus.s_start}, 32'd0);
        checkOutput("midreset_bus_done", {31'd0, bus.bus_done}, 32'd0);
        lat[0] = 8'd0;
        applyStimulus(27'h0000020, 32'h0, 1'b0, 4'b0001, 27'h20, 32'hCAFEBABE, 1'b0, 1'b0, 2);

        repeat (3) @(negedge clk);
        checkOutput("queues_empty", 32'(req_q.size() + rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_router.md
Name: mem_bus_router

Overview:
- Sits directly downstream of the CPU memory-bus arbiter.
- Consumes its single start/done request bus and decodes the 27-bit word address into one of four slave regions: SDRAM, SPI flash, VRAM, I/O.
- Drives the selected slave with a held start/done handshake and returns read data and completion to the arbiter.
- Also handles unmapped addresses and hung slaves, so the CPU can never stall forever.

Parameters:
- S0_BASE, 27'h0000000, first word of region 0 (SDRAM)
- S0_SIZE, 27'h0800000, number of words in region 0
- S1_BASE, 27'h0800000, first word of region 1 (flash)
- S1_SIZE, 27'h0400000, words in region 1
- S2_BASE, 27'h0C00000, first word of region 2 (VRAM)
- S2_SIZE, 27'h0010000, words in region 2
- S3_BASE, 27'h0C10000, first word of region 3 (I/O)
- S3_SIZE, 27'h0000100, words in region 3
- TIMEOUT, 1023, maximum cycles to wait for slave done; valid range 2..1023
- ERR_DATA, 32'h00000000, q value returned on unmapped or timed-out access

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bus_addr  in  27  word address from arbiter
- bus_data  in  32  write data
- bus_we  in  1  1 = write
- bus_start  in  1  request; held high until bus_done
- bus_q  out  32  read data, valid while bus_done = 1
- bus_done  out  1  one-cycle completion pulse
- s_addr  out  27  slave-local address (bus_addr - region base)
- s_data  out  32  write data to slaves
- s_we  out  1  write enable to slaves
- s_start  out  4  one-hot start, bit i = region i
- s_done  in  4  per-slave done
- s_q0, s_q1, s_q2, s_q3  in  32 each  per-slave read data
- err_unmapped  out  1  one-cycle pulse: access outside all regions
- err_timeout  out  1  one-cycle pulse: slave did not answer within TIMEOUT

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values: all outputs are registered and reset to 0; state = IDLE; timeout counter = 0.
- Decode: region i matches when BASE_i <= addr < BASE_i + SIZE_i, using 27-bit unsigned compares. Regions never overlap; the lowest index wins if a misconfiguration overlaps them.
- State IDLE:
  - If bus_start = 1, latch addr, data and we.
  - Region hit: s_addr <= addr - BASE_i, s_start[i] <= 1, go to ACCESS.
  - No hit: bus_q <= ERR_DATA, bus_done <= 1, err_unmapped <= 1, go to DONE.
  - Unmapped latency is therefore 1 cycle.
- State ACCESS:
  - s_start[i] stays high and s_addr, s_data, s_we stay stable.
  - Counter increments every cycle.
  - Only s_done[i] of the selected slave is honoured; other done bits are ignored.
  - On s_done[i] = 1: bus_q <= s_qi, bus_done <= 1, s_start <= 0, go to DONE.
  - Else if counter == TIMEOUT-1: bus_q <= ERR_DATA, bus_done <= 1, err_timeout <= 1, s_start <= 0, go to DONE.
  - If done and timeout occur in the same cycle, done wins.
- State DONE:
  - bus_done, err_unmapped and err_timeout are high for exactly this cycle.
  - bus_start is ignored (the arbiter masks it while done).
  - Next cycle: clear bus_done and error flags, counter = 0, go to IDLE.
- Latency: slave done in cycle N (ACCESS) -> bus_done in cycle N+1.
- Minimum mapped access: start seen at T0, s_start at T1, combinational s_done at T1, bus_done at T2.
- Back-to-back requests: the earliest new acceptance is the cycle after DONE, in IDLE.
- Writes: bus_q on write completion carries s_qi unmodified; the arbiter ignores it.
- Reset mid-operation: immediately return to IDLE and drop s_start and bus_done. The outstanding slave access is abandoned; slaves must tolerate start falling before done.
- Late done: an s_done arriving after timeout (in IDLE or DONE) is ignored.

Test Plan:
- Read SDRAM: bus_addr = 27'h0000010, we = 0, slave 0 answers done after 3 cycles with q = 32'hCAFEBABE -> s_start = 4'b0001, s_addr = 27'h10, bus_q = 32'hCAFEBABE, bus_done pulses 1 cycle, 4 cycles after start seen.
- Write I/O with base offset: bus_addr = 27'h0C10005, data = 32'h12345678, we = 1 -> s_start = 4'b1000, s_addr = 27'h5, s_data = 32'h12345678, s_we = 1, bus_done after slave done.
- Unmapped access: bus_addr = 27'h7FFFFFF -> no s_start bit set; bus_done and err_unmapped high 1 cycle after start; bus_q = ERR_DATA.
- Timeout: TIMEOUT = 8, flash region addressed, slave never answers -> s_start[1] held for 8 cycles, then bus_done = 1 and err_timeout = 1 with bus_q = 0; a late s_done[1] is ignored.
- Wrong-slave done plus boundaries: s_done[2] asserted during a region 0 access -> ignored. Accesses at 27'h07FFFFF and 27'h0800000 select region 0 and region 1 respectively.
- Reset mid-ACCESS, then reuse: reset pulsed while ACCESS is pending -> next cycle s_start = 0, bus_done = 0, state IDLE; a following read completes normally.
